// File: rtl/slice_l.sv
// Configurable logic slice: four fracturable S44 LUT pairs, F7/F8 wide-function muxes,
// a ripple carry chain and eight output flip-flops, all driven by stored configuration.
module slice_l #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int CFG_SIZE  = 2 * 2**S_XX_BASE + 1,
    parameter int MUX_LVLS  = $clog2(NUM_LUTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cen,
    input  logic                              reg_ce,
    input  logic [2*S_XX_BASE*NUM_LUTS-1:0]   luts_in,
    input  logic [MUX_LVLS-1:0]               higher_order_addr,
    input  logic                              Ci,
    input  logic [CFG_SIZE*NUM_LUTS-1:0]      luts_config_in,
    input  logic [MUX_LVLS-1:0]               inter_lut_mux_config,
    input  logic                              config_use_cc,
    input  logic [2*NUM_LUTS-1:0]             regs_config_in,
    output logic                              Co,
    output logic [2*NUM_LUTS-1:0]             out,
    output logic [2*NUM_LUTS-1:0]             sync_out
);

    localparam int TT = 2**S_XX_BASE;

    logic [CFG_SIZE*NUM_LUTS-1:0] lut_cfg_q;
    logic [MUX_LVLS-1:0]          mux_cfg_q;
    logic                         use_cc_q;

    logic [NUM_LUTS-1:0] o0;
    logic [NUM_LUTS-1:0] o1;
    logic                f7a;
    logic                f7b;
    logic                f8;
    logic                carry;

    // o1 always reads table B at address b; o0 borrows table B when fused and b[0] is set.
    function automatic logic [1:0] s44(input logic [CFG_SIZE-1:0]    cfg,
                                       input logic [2*S_XX_BASE-1:0] addr);
        logic [S_XX_BASE-1:0] a;
        logic [S_XX_BASE-1:0] b;
        logic [TT-1:0]        tt_a;
        logic [TT-1:0]        tt_b;
        logic                 lo;
        a    = addr[S_XX_BASE-1:0];
        b    = addr[2*S_XX_BASE-1:S_XX_BASE];
        tt_a = cfg[TT-1:0];
        tt_b = cfg[2*TT-1:TT];
        lo   = (cfg[CFG_SIZE-1] && b[0]) ? tt_b[a] : tt_a[a];
        return {tt_b[b], lo};
    endfunction

    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_s44
        assign {o1[k], o0[k]} = s44(lut_cfg_q[k*CFG_SIZE +: CFG_SIZE],
                                    luts_in[k*2*S_XX_BASE +: 2*S_XX_BASE]);
    end

    assign f7a = higher_order_addr[0] ? o0[1] : o0[0];
    assign f7b = higher_order_addr[0] ? o0[3] : o0[2];
    assign f8  = higher_order_addr[1] ? f7b : f7a;

    // Carry rewrites only even bits, muxes only odd bits, so the two never collide.
    always_comb begin
        out   = '0;
        carry = Ci;
        for (int k = 0; k < NUM_LUTS; k++) begin
            out[2*k]   = o0[k];
            out[2*k+1] = o1[k];
            if (use_cc_q) begin
                out[2*k] = o0[k] ^ carry;
                carry    = o0[k] ? carry : o1[k];
            end
        end
        if (mux_cfg_q[0]) begin
            out[1] = f7a;
            out[5] = f7b;
        end
        if (mux_cfg_q[1]) begin
            out[3] = f8;
        end
        Co = use_cc_q ? carry : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_cfg_q <= '0;
            mux_cfg_q <= '0;
            use_cc_q  <= 1'b0;
        end else if (cen) begin
            lut_cfg_q <= luts_config_in;
            mux_cfg_q <= inter_lut_mux_config;
            use_cc_q  <= config_use_cc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_out <= '0;
        end else if (cen) begin
            sync_out <= regs_config_in;
        end else if (reg_ce) begin
            sync_out <= out;
        end
    end

endmodule

// File: tb/tb_slice_l.sv
// Directed bench for slice_l: reset, LUT tables, F7/F8, fuse mode, carry chain and flip-flop control.
module tb_slice_l;

    logic         clk;
    logic         rst_n;
    logic         cen;
    logic         reg_ce;
    logic [31:0]  luts_in;
    logic [1:0]   higher_order_addr;
    logic         Ci;
    logic [131:0] luts_config_in;
    logic [1:0]   inter_lut_mux_config;
    logic         config_use_cc;
    logic [7:0]   regs_config_in;
    logic         Co;
    logic [7:0]   out;
    logic [7:0]   sync_out;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    slice_l dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cen                  (cen),
        .reg_ce               (reg_ce),
        .luts_in              (luts_in),
        .higher_order_addr    (higher_order_addr),
        .Ci                   (Ci),
        .luts_config_in       (luts_config_in),
        .inter_lut_mux_config (inter_lut_mux_config),
        .config_use_cc        (config_use_cc),
        .regs_config_in       (regs_config_in),
        .Co                   (Co),
        .out                  (out),
        .sync_out             (sync_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [131:0] cfg4(input logic [32:0] c0, input logic [32:0] c1,
                                          input logic [32:0] c2, input logic [32:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [131:0] cfg, input logic [1:0] mux, input logic cc,
                            input logic [7:0] regs, input int edges);
        luts_config_in       = cfg;
        inter_lut_mux_config = mux;
        config_use_cc        = cc;
        regs_config_in       = regs;
        cen                  = 1'b1;
        for (int i = 0; i < edges; i++) tick();
        cen = 1'b0;
    endtask

    // Scoreboard: expected value enters the queue at the step, leaves at the comparison
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        logic [7:0] e;
        exp_q.push_back(expv);
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    endtask

    initial begin
        rst_n                = 1'b0;
        cen                  = 1'b0;
        reg_ce               = 1'b0;
        luts_in              = 32'h1234_5678;
        higher_order_addr    = 2'b00;
        Ci                   = 1'b0;
        luts_config_in       = '0;
        inter_lut_mux_config = 2'b00;
        config_use_cc        = 1'b0;
        regs_config_in       = 8'h00;
        #12;
        check("reset_sync", sync_out, 8'h00);
        check("reset_out", out, 8'h00);
        check("reset_co", {7'b0, Co}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones tables, preset flops to A5
        load_cfg(cfg4(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF),
                 2'b00, 1'b0, 8'hA5, 2);
        check("ones_sync_preset", sync_out, 8'hA5);
        check("ones_out", out, 8'hFF);
        reg_ce = 1'b1;
        tick();
        tick();
        reg_ce = 1'b0;
        check("ones_sync_capture", sync_out, 8'hFF);

        // Asynchronous reset mid-run, away from any edge
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_sync", sync_out, 8'h00);
        check("midreset_out", out, 8'h00);
        check("midreset_co", {7'b0, Co}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // F7/F8: only LUT0 table A is all ones
        luts_in = 32'h0000_0000;
        load_cfg(cfg4(33'h0_0000_FFFF, 33'h0, 33'h0, 33'h0), 2'b11, 1'b0, 8'h3C, 1);
        check("f78_sync_preset", sync_out, 8'h3C);
        higher_order_addr = 2'b00; #1;
        check("f78_hoa00", out, 8'h0B);
        higher_order_addr = 2'b01; #1;
        check("f78_hoa01", out, 8'h01);
        higher_order_addr = 2'b10; #1;
        check("f78_hoa10", out, 8'h03);
        higher_order_addr = 2'b11; #1;
        check("f78_hoa11", out, 8'h01);
        higher_order_addr = 2'b00;

        // Fuse mode on LUT0: A=0, B=all ones
        load_cfg(cfg4(33'h1_FFFF_0000, 33'h0, 33'h0, 33'h0), 2'b00, 1'b0, 8'h5A, 1);
        luts_in = 32'h0000_0010; #1;
        check("fuse_b0_set", out, 8'h03);
        luts_in = 32'h0000_0000; #1;
        check("fuse_b0_clr", out, 8'h02);
        luts_in = 32'h0000_0020; #1;
        check("fuse_b2", out, 8'h02);
        luts_in = 32'h0000_0031; #1;
        check("fuse_b3", out, 8'h03);

        // Hold: flops keep the preset while out moves
        tick();
        luts_in = 32'h0000_0000;
        tick();
        check("hold_sync", sync_out, 8'h5A);
        check("hold_out", out, 8'h02);
        luts_in = 32'h0000_0010;
        reg_ce  = 1'b1;
        tick();
        reg_ce  = 1'b0;
        check("regce_capture", sync_out, 8'h03);
        reg_ce = 1'b1;
        load_cfg(cfg4(33'h1_FFFF_0000, 33'h0, 33'h0, 33'h0), 2'b00, 1'b0, 8'hC3, 1);
        reg_ce = 1'b0;
        check("cen_beats_regce", sync_out, 8'hC3);

        // Carry chain: p=1 everywhere, g=0; new config only visible after the edge
        luts_in              = 32'h0000_0000;
        Ci                   = 1'b1;
        luts_config_in       = cfg4(33'h0_0000_FFFF, 33'h0_0000_FFFF, 33'h0_0000_FFFF, 33'h0_0000_FFFF);
        config_use_cc        = 1'b1;
        #1;
        check("cfg_latency_out", out, 8'h02);
        load_cfg(luts_config_in, 2'b00, 1'b1, 8'h00, 1);
        check("cc_ci1_out", out, 8'h00);
        check("cc_ci1_co", {7'b0, Co}, 8'h01);
        Ci = 1'b0; #1;
        check("cc_ci0_out", out, 8'h55);
        check("cc_ci0_co", {7'b0, Co}, 8'h00);

        // Carry generate: p=0, g=1 everywhere
        load_cfg(cfg4(33'h0_FFFF_0000, 33'h0_FFFF_0000, 33'h0_FFFF_0000, 33'h0_FFFF_0000),
                 2'b00, 1'b1, 8'h00, 1);
        Ci = 1'b0; #1;
        check("cc_gen_out", out, 8'hFE);
        check("cc_gen_co", {7'b0, Co}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
